// File: rtl/rn_ds_pipe.sv
// rtl/rn_ds_pipe.sv - rename-to-dispatch pipeline register with one skid entry,
// optional lane compaction and per-lane PC generation.
module rn_ds_pipe #(
   parameter int LANES   = 4,
   parameter int ALUOP_W = 9,
   parameter int AREG_W  = 5,
   parameter int PREG_W  = 6,
   parameter int IMM_W   = 32,
   parameter int PC_W    = 32,
   parameter bit COMPACT = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        rn_valid,
   output logic                        rn_ready,
   input  logic [PC_W-1:0]             rn_pc,
   input  logic [LANES-1:0]            rn_lane_valid,
   input  logic [LANES*ALUOP_W-1:0]    rn_aluop,
   input  logic [LANES*AREG_W-1:0]     rn_src1,
   input  logic [LANES*AREG_W-1:0]     rn_src2,
   input  logic [LANES*AREG_W-1:0]     rn_rdst,
   input  logic [LANES*PREG_W-1:0]     rn_psrc1,
   input  logic [LANES*PREG_W-1:0]     rn_psrc2,
   input  logic [LANES*PREG_W-1:0]     rn_pdst,
   input  logic [LANES*IMM_W-1:0]      rn_imm,
   output logic                        ds_valid,
   input  logic                        ds_ready,
   output logic [LANES-1:0]            ds_lane_valid,
   output logic [LANES*PC_W-1:0]       ds_lane_pc,
   output logic [LANES*ALUOP_W-1:0]    ds_aluop,
   output logic [LANES*AREG_W-1:0]     ds_src1,
   output logic [LANES*AREG_W-1:0]     ds_src2,
   output logic [LANES*AREG_W-1:0]     ds_rdst,
   output logic [LANES*PREG_W-1:0]     ds_psrc1,
   output logic [LANES*PREG_W-1:0]     ds_psrc2,
   output logic [LANES*PREG_W-1:0]     ds_pdst,
   output logic [LANES*IMM_W-1:0]      ds_imm,
   output logic [$clog2(LANES+1)-1:0]  ds_count
);
   // One lane record, valid in bit 0 so compaction moves it with its fields.
   localparam int O_IMM   = 1;
   localparam int O_PDST  = O_IMM + IMM_W;
   localparam int O_PSRC2 = O_PDST + PREG_W;
   localparam int O_PSRC1 = O_PSRC2 + PREG_W;
   localparam int O_RDST  = O_PSRC1 + PREG_W;
   localparam int O_SRC2  = O_RDST + AREG_W;
   localparam int O_SRC1  = O_SRC2 + AREG_W;
   localparam int O_ALU   = O_SRC1 + AREG_W;
   localparam int O_PC    = O_ALU + ALUOP_W;
   localparam int LW      = O_PC + PC_W;
   localparam int CW      = $clog2(LANES+1);

   logic [LW-1:0]       lane_in [LANES];
   logic [LANES*LW-1:0] group;
   logic [LANES*LW-1:0] main_data;
   logic [LANES*LW-1:0] skid_data;
   logic                main_valid;
   logic                skid_full;
   logic                accept;
   logic                xfer;

   for (genvar i = 0; i < LANES; i++) begin : g_in
      // PC is taken from the original lane index, before any compaction.
      assign lane_in[i] = {rn_pc + PC_W'(4*i),
                           rn_aluop[i*ALUOP_W +: ALUOP_W],
                           rn_src1[i*AREG_W +: AREG_W],
                           rn_src2[i*AREG_W +: AREG_W],
                           rn_rdst[i*AREG_W +: AREG_W],
                           rn_psrc1[i*PREG_W +: PREG_W],
                           rn_psrc2[i*PREG_W +: PREG_W],
                           rn_pdst[i*PREG_W +: PREG_W],
                           rn_imm[i*IMM_W +: IMM_W],
                           rn_lane_valid[i]};
   end

   always_comb begin
      int k;
      group = '0;
      k = 0;
      for (int i = 0; i < LANES; i++) begin
         if (!COMPACT) begin
            group[i*LW +: LW] = lane_in[i];
         end else if (rn_lane_valid[i]) begin
            group[k*LW +: LW] = lane_in[i];
            k = k + 1;
         end
      end
   end

   // Empty groups still handshake but never enter storage.
   assign accept = rn_valid && rn_ready && (|rn_lane_valid);
   assign xfer   = main_valid && ds_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         skid_full  <= 1'b0;
         skid_data  <= '0;
         rn_ready   <= 1'b1;
      end else if (flush) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         skid_full  <= 1'b0;
         rn_ready   <= 1'b1;
      end else if (!main_valid || xfer) begin
         if (skid_full) begin
            main_valid <= 1'b1;
            main_data  <= skid_data;
         end else if (accept) begin
            main_valid <= 1'b1;
            main_data  <= group;
         end else begin
            main_valid <= 1'b0;
            main_data  <= '0;
         end
         skid_full <= 1'b0;
         rn_ready  <= 1'b1;
      end else if (accept) begin
         skid_full <= 1'b1;
         skid_data <= group;
         rn_ready  <= 1'b0;
      end
   end

   assign ds_valid = main_valid;

   for (genvar i = 0; i < LANES; i++) begin : g_out
      assign ds_lane_valid[i]                = main_data[i*LW];
      assign ds_imm[i*IMM_W +: IMM_W]        = main_data[i*LW + O_IMM   +: IMM_W];
      assign ds_pdst[i*PREG_W +: PREG_W]     = main_data[i*LW + O_PDST  +: PREG_W];
      assign ds_psrc2[i*PREG_W +: PREG_W]    = main_data[i*LW + O_PSRC2 +: PREG_W];
      assign ds_psrc1[i*PREG_W +: PREG_W]    = main_data[i*LW + O_PSRC1 +: PREG_W];
      assign ds_rdst[i*AREG_W +: AREG_W]     = main_data[i*LW + O_RDST  +: AREG_W];
      assign ds_src2[i*AREG_W +: AREG_W]     = main_data[i*LW + O_SRC2  +: AREG_W];
      assign ds_src1[i*AREG_W +: AREG_W]     = main_data[i*LW + O_SRC1  +: AREG_W];
      assign ds_aluop[i*ALUOP_W +: ALUOP_W]  = main_data[i*LW + O_ALU   +: ALUOP_W];
      assign ds_lane_pc[i*PC_W +: PC_W]      = main_data[i*LW + O_PC    +: PC_W];
   end

   always_comb begin
      ds_count = '0;
      for (int i = 0; i < LANES; i++) begin
         ds_count = ds_count + CW'(ds_lane_valid[i]);
      end
   end
endmodule

// File: tb/tb_rn_ds_pipe.sv
// tb/tb_rn_ds_pipe.sv - scoreboard bench for rn_ds_pipe (LANES=4, COMPACT=1).
module tb_rn_ds_pipe;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         rn_valid = 1'b0;
   logic         rn_ready;
   logic [31:0]  rn_pc = '0;
   logic [3:0]   rn_lane_valid = '0;
   logic [35:0]  rn_aluop = '0;
   logic [19:0]  rn_src1 = '0, rn_src2 = '0, rn_rdst = '0;
   logic [23:0]  rn_psrc1 = '0, rn_psrc2 = '0, rn_pdst = '0;
   logic [127:0] rn_imm = '0;
   logic         ds_valid;
   logic         ds_ready = 1'b0;
   logic [3:0]   ds_lane_valid;
   logic [127:0] ds_lane_pc;
   logic [35:0]  ds_aluop;
   logic [19:0]  ds_src1, ds_src2, ds_rdst;
   logic [23:0]  ds_psrc1, ds_psrc2, ds_pdst;
   logic [127:0] ds_imm;
   logic [2:0]   ds_count;

   rn_ds_pipe dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .rn_valid(rn_valid), .rn_ready(rn_ready), .rn_pc(rn_pc),
      .rn_lane_valid(rn_lane_valid), .rn_aluop(rn_aluop),
      .rn_src1(rn_src1), .rn_src2(rn_src2), .rn_rdst(rn_rdst),
      .rn_psrc1(rn_psrc1), .rn_psrc2(rn_psrc2), .rn_pdst(rn_pdst),
      .rn_imm(rn_imm),
      .ds_valid(ds_valid), .ds_ready(ds_ready), .ds_lane_valid(ds_lane_valid),
      .ds_lane_pc(ds_lane_pc), .ds_aluop(ds_aluop),
      .ds_src1(ds_src1), .ds_src2(ds_src2), .ds_rdst(ds_rdst),
      .ds_psrc1(ds_psrc1), .ds_psrc2(ds_psrc2), .ds_pdst(ds_pdst),
      .ds_imm(ds_imm), .ds_count(ds_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   lv;
      logic [127:0] pc;
      logic [23:0]  pdst;
      logic [127:0] imm;
      logic [2:0]   cnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic push(input logic [3:0] lv, input logic [127:0] pc,
                       input logic [23:0] pdst, input logic [127:0] imm, input logic [2:0] cnt);
      exp_t e;
      e.lv = lv; e.pc = pc; e.pdst = pdst; e.imm = imm; e.cnt = cnt;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && ds_valid && ds_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_group", {96'd0, ds_lane_pc[31:0]}, 128'hDEAD);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("lane_valid", 128'(ds_lane_valid), 128'(e.lv));
            chk("lane_pc", ds_lane_pc, e.pc);
            chk("pdst", 128'(ds_pdst), 128'(e.pdst));
            chk("imm", ds_imm, e.imm);
            chk("count", 128'(ds_count), 128'(e.cnt));
         end
      end
   end

   // Holds the group on rn_* until accepted, sampling rn_ready away from the edge.
   task automatic send(input logic [31:0] pc, input logic [3:0] lv,
                       input logic [23:0] pdst, input logic [127:0] imm);
      logic acc;
      int   n;
      rn_pc = pc; rn_lane_valid = lv; rn_pdst = pdst; rn_imm = imm;
      rn_aluop = {4{9'h1A5}}; rn_src1 = {4{5'h3}}; rn_src2 = {4{5'h7}};
      rn_rdst = {4{5'h9}}; rn_psrc1 = {4{6'h21}}; rn_psrc2 = {4{6'h2A}};
      rn_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = rn_ready;
         @(posedge clk);
         #1;
         n++;
      end
      chk("accept", 128'(acc), 128'd1);
      rn_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      idle(2);
      chk("rst_ds_valid", 128'(ds_valid), 128'd0);
      chk("rst_lane_valid", 128'(ds_lane_valid), 128'd0);
      chk("rst_count", 128'(ds_count), 128'd0);
      chk("rst_rn_ready", 128'(rn_ready), 128'd1);
      chk("rst_pdst", 128'(ds_pdst), 128'd0);
      rst_n = 1'b1;
      idle(1);

      // Basic group, then compaction of lanes 1 and 3.
      ds_ready = 1'b1;
      push(4'b1111, {32'h100C, 32'h1008, 32'h1004, 32'h1000}, {6'h4, 6'h3, 6'h2, 6'h1},
           {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 3'd4);
      send(32'h1000, 4'b1111, {6'h4, 6'h3, 6'h2, 6'h1}, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      chk("latency_ds_valid", 128'(ds_valid), 128'd1);
      push(4'b0011, {64'd0, 32'h200C, 32'h2004}, {6'h0, 6'h0, 6'h33, 6'h11},
           {64'd0, 32'hB3, 32'hB1}, 3'd2);
      send(32'h2000, 4'b1010, {6'h33, 6'h22, 6'h11, 6'h05}, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
      idle(3);

      // Backpressure: A in main, B in skid, C refused until release.
      ds_ready = 1'b0;
      push(4'b1111, {32'h300C, 32'h3008, 32'h3004, 32'h3000}, {4{6'h0A}}, {4{32'hC0}}, 3'd4);
      push(4'b1111, {32'h310C, 32'h3108, 32'h3104, 32'h3100}, {4{6'h0B}}, {4{32'hC1}}, 3'd4);
      push(4'b1111, {32'h320C, 32'h3208, 32'h3204, 32'h3200}, {4{6'h0C}}, {4{32'hC2}}, 3'd4);
      send(32'h3000, 4'b1111, {4{6'h0A}}, {4{32'hC0}});
      send(32'h3100, 4'b1111, {4{6'h0B}}, {4{32'hC1}});
      rn_pc = 32'h3200; rn_pdst = {4{6'h0C}}; rn_imm = {4{32'hC2}}; rn_valid = 1'b1;
      chk("skid_full_rn_ready", 128'(rn_ready), 128'd0);
      idle(2);
      chk("skid_hold_rn_ready", 128'(rn_ready), 128'd0);
      chk("skid_hold_main_pc", 128'(ds_lane_pc[31:0]), 128'h3000);
      ds_ready = 1'b1;
      idle(1);
      chk("release_rn_ready", 128'(rn_ready), 128'd1);
      send(32'h3200, 4'b1111, {4{6'h0C}}, {4{32'hC2}});
      idle(4);

      // Flush with main and skid full and a group offered.
      ds_ready = 1'b0;
      send(32'h4000, 4'b1111, {4{6'h3D}}, {4{32'hD0}});
      send(32'h4100, 4'b1111, {4{6'h3E}}, {4{32'hD1}});
      rn_pc = 32'h4200; rn_imm = {4{32'hD2}}; rn_valid = 1'b1; flush = 1'b1;
      idle(1);
      flush = 1'b0; rn_valid = 1'b0;
      chk("flush_ds_valid", 128'(ds_valid), 128'd0);
      chk("flush_rn_ready", 128'(rn_ready), 128'd1);
      ds_ready = 1'b1;
      idle(4);

      // Empty group between two valid groups is dropped.
      push(4'b0001, {96'd0, 32'h5000}, {18'd0, 6'h15}, {96'd0, 32'hE0}, 3'd1);
      push(4'b1111, {32'h610C, 32'h6108, 32'h6104, 32'h6100}, {4{6'h16}}, {4{32'hE1}}, 3'd4);
      send(32'h5000, 4'b0001, {4{6'h15}}, {4{32'hE0}});
      send(32'h5800, 4'b0000, {4{6'h2F}}, {4{32'hEE}});
      send(32'h6100, 4'b1111, {4{6'h16}}, {4{32'hE1}});
      idle(4);

      // PC wrap at the top of the address space.
      push(4'b1111, {32'h4, 32'h0, 32'hFFFFFFFC, 32'hFFFFFFF8}, {4{6'h17}}, {4{32'hF0}}, 3'd4);
      send(32'hFFFFFFF8, 4'b1111, {4{6'h17}}, {4{32'hF0}});
      idle(3);

      // Asynchronous reset while a group is held.
      ds_ready = 1'b0;
      send(32'h7000, 4'b1111, {4{6'h18}}, {4{32'hF1}});
      chk("pre_reset_ds_valid", 128'(ds_valid), 128'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_ds_valid", 128'(ds_valid), 128'd0);
      chk("async_rst_lane_pc", ds_lane_pc, 128'd0);
      chk("async_rst_count", 128'(ds_count), 128'd0);
      chk("async_rst_rn_ready", 128'(rn_ready), 128'd1);
      idle(2);
      rst_n = 1'b1;
      ds_ready = 1'b1;
      idle(3);

      chk("scoreboard_drained", 128'(q.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rn_ds_pipe.md
# rn_ds_pipe

Parametrised rename-to-dispatch pipeline register for the superscalar core. It carries one group of LANES renamed instructions per transfer under a valid/ready handshake and absorbs one group of backpressure in a skid entry. It optionally compacts valid lanes toward lane 0 and generates per-lane PCs. It sits between the rename stage and the dispatch/issue-queue write logic.

## Interface
Parameters:
- LANES, 4, instructions per group (1..8)
- ALUOP_W, 9, ALU opcode width
- AREG_W, 5, architectural register index width
- PREG_W, 6, physical register index width
- IMM_W, 32, immediate width
- PC_W, 32, PC width
- COMPACT, 1, 1 = pack valid lanes to the lowest indices, order preserved; 0 = lanes pass in place

Ports (lane i occupies bits [i*W +: W] of each bus):
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all held groups
- rn_valid  in  1  rename presents a group
- rn_ready  out  1  block can accept a group; registered
- rn_pc  in  PC_W  PC of lane 0 of the group
- rn_lane_valid  in  LANES  per-lane valid
- rn_aluop  in  LANES*ALUOP_W
- rn_src1, rn_src2, rn_rdst  in  LANES*AREG_W  architectural sources and destination
- rn_psrc1, rn_psrc2, rn_pdst  in  LANES*PREG_W  physical sources and destination
- rn_imm  in  LANES*IMM_W
- ds_valid  out  1  group held at the output
- ds_ready  in  1  dispatch consumes the group
- ds_lane_valid  out  LANES
- ds_lane_pc  out  LANES*PC_W  per-lane PC
- ds_aluop, ds_src1, ds_src2, ds_rdst, ds_psrc1, ds_psrc2, ds_pdst, ds_imm  out  widths as inputs
- ds_count  out  $clog2(LANES+1)  popcount of ds_lane_valid

## Operation
- Accept occurs when rn_valid && rn_ready. Transfer occurs when ds_valid && ds_ready.
- Storage is a main entry (drives ds_*) plus one skid entry. rn_ready is !skid_full, registered.
- Empty groups (rn_lane_valid == 0) complete the handshake but are dropped. State is unchanged.
- Lane PC: lane_pc[i] = rn_pc + 4*i, computed on the original lane index before compaction, modulo 2^PC_W.
- COMPACT=1: valid lanes move to indices 0..k-1 in original order, with all fields and PC moving together. Lanes k..LANES-1 have valid 0 and all fields 0.
- COMPACT=0: lanes pass in place. Fields of invalid lanes are passed unmodified.
- Update rules, in priority order:
  - flush: main and skid become empty, and any accept in that cycle is discarded.
  - Main empty or transferring: main loads the skid if skid is full, else the accepted group; otherwise main goes empty.
  - Main full, not transferring, accept: the group goes to the skid.
  - Skid is never written while full.
- Groups leave in acceptance order. No group is duplicated or lost except by flush or the empty-group rule.
- Reset (rst_n low, asynchronous): ds_valid=0, ds_lane_valid=0, all ds_* data=0, ds_count=0, skid empty, rn_ready=1. Reset mid-stream discards all held groups.

## Timing
- Latency: a group accepted at edge N appears on ds_* after edge N, so ds_valid is high in cycle N+1.
- Throughput: one group per cycle while ds_ready stays high. The skid is never used in this case.
- Backpressure: ds_ready low with main full plus an accept fills the skid. rn_ready falls the following cycle, so at most one extra group is absorbed.
- Release: the first ds_ready transfer moves the skid into main at that edge. rn_ready rises the next cycle.
- flush: ds_valid=0 and rn_ready=1 in the cycle after the flush edge. flush is ignored while rst_n is low.
- ds_count is combinational from the main entry, with no extra latency.

## Test plan
- Reset, then one group with rn_pc=0x1000, lane_valid=4'b1111, ds_ready=1 -> ds_valid next cycle, lane PCs 0x1000/0x1004/0x1008/0x100C, ds_count=4.
- COMPACT=1, lane_valid=4'b1010, pdst lanes {3:0x33, 1:0x11} -> ds_lane_valid=4'b0011, ds_pdst lane0=0x11, lane1=0x33, PCs base+4 and base+12.
- Hold ds_ready=0 and offer groups A, B, C on back-to-back cycles -> A in main, B in skid, rn_ready=0 and C not accepted. Raise ds_ready -> A, B, C emerge in order with no loss.
- Assert flush while main and skid are full and rn_valid=1 -> next cycle ds_valid=0, rn_ready=1, and none of the held groups or the flushed-cycle input ever appears.
- Offer an empty group (lane_valid=0) between two valid groups with ds_ready=1 -> only the two valid groups emerge, back to back.
- rn_pc=0xFFFFFFF8, all lanes valid -> lane PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4. Pull rst_n low mid-transfer -> all outputs 0 immediately and rn_ready=1.
